// File: rtl/wb_stream_hub_pkg.sv
// Shared constants for the Wishbone-to-stream hub.
// Register offsets, ROUTE/STATUS/CLEAR bit positions, ack FSM states.
package wb_stream_hub_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_ROUTE  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int ROUTE_OUT_LSB = 0;
  localparam int ROUTE_IN_LSB  = 16;

  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_OVF        = 16;
  localparam int ST_UNF        = 17;
  localparam int ST_TX_FULL    = 18;
  localparam int ST_RX_EMPTY   = 19;

  localparam int CLR_FLAGS = 0;
  localparam int CLR_FLUSH = 1;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_e;

endpackage

// File: rtl/wb_stream_hub_fifo.sv
// stream_fifo: DEPTH-entry valid/ready FIFO with flush and count.
// Ports: push_valid/ready/data, pop_valid/ready/data, count, flush.
module stream_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [W-1:0]               push_data,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign push_ready = (count != CNTW'(DEPTH));
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_valid & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNTW'(do_push)
                     - CNTW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_stream_hub.sv
// Wishbone slave buffering host words into a TX FIFO toward N_CH streams
// and collecting one selected stream into an RX FIFO for host reads.
module wb_stream_hub
  import wb_stream_hub_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          N_CH      = 4,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [N_CH-1:0]          m_val,
  output logic [N_CH*DATA_W-1:0]   m_data,
  input  logic [N_CH-1:0]          m_rdy,
  input  logic [N_CH-1:0]          s_val,
  input  logic [N_CH*DATA_W-1:0]   s_data,
  output logic [N_CH-1:0]          s_rdy
);

  localparam int CW   = $clog2(N_CH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  ack_state_e state;
  ack_state_e state_nxt;

  logic [1:0]        off;
  logic              hit;
  logic              req;
  logic              wr_dat;
  logic              wr_route;
  logic              wr_clear;
  logic              rd_req;
  logic              rd_dat;
  logic              flush;

  logic [CW-1:0]     out_sel;
  logic [CW-1:0]     in_sel;
  logic              ovf;
  logic              unf;

  logic              tx_ready;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_head;
  logic [CNTW-1:0]   tx_cnt;
  logic              rx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_head;
  logic [CNTW-1:0]   rx_cnt;

  logic [31:0]       status;
  logic [31:0]       rd_word;
  logic              unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  assign off = wbs_adr_i[3:2];
  assign hit = wbs_stb_i & wbs_cyc_i
             & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // Held requests are not re-sampled while ack is up.
  assign req = hit & (state == ACK_IDLE);

  assign wr_dat   = req & wbs_we_i & (off == REG_DATA);
  assign wr_route = req & wbs_we_i & (off == REG_ROUTE);
  assign wr_clear = req & wbs_we_i & (off == REG_CLEAR);
  assign rd_req   = req & ~wbs_we_i;
  assign rd_dat   = rd_req & (off == REG_DATA);
  assign flush    = wr_clear & wbs_dat_i[CLR_FLUSH];

  function automatic logic [CW-1:0] fix_sel(
    input logic [CW-1:0] v
  );
    logic [31:0] wide;
    wide = 32'(v);
    return (wide >= 32'(N_CH)) ? '0 : v;
  endfunction

  stream_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_tx (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_i),
    .flush      (flush),
    .push_valid (wr_dat),
    .push_ready (tx_ready),
    .push_data  (wbs_dat_i[DATA_W-1:0]),
    .pop_valid  (tx_valid),
    .pop_ready  (m_rdy[out_sel]),
    .pop_data   (tx_head),
    .count      (tx_cnt)
  );

  stream_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_rx (
    .clk        (wb_clk_i),
    .rst_n      (wb_rst_i),
    .flush      (flush),
    .push_valid (s_val[in_sel] & wb_rst_i),
    .push_ready (rx_ready),
    .push_data  (s_data[in_sel*DATA_W +: DATA_W]),
    .pop_valid  (rx_valid),
    .pop_ready  (rd_dat),
    .pop_data   (rx_head),
    .count      (rx_cnt)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= ACK_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACK_IDLE: if (hit) state_nxt = ACK_BUSY;
      ACK_BUSY: state_nxt = ACK_IDLE;
      default:  state_nxt = ACK_IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = (state == ACK_BUSY);
  end

  always_comb begin
    status = '0;
    status[ST_TX_CNT_LSB +: 8] = 8'(tx_cnt);
    status[ST_RX_CNT_LSB +: 8] = 8'(rx_cnt);
    status[ST_OVF]      = ovf;
    status[ST_UNF]      = unf;
    status[ST_TX_FULL]  = ~tx_ready;
    status[ST_RX_EMPTY] = ~rx_valid;
  end

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      off == REG_DATA: begin
        if (rx_valid) rd_word[DATA_W-1:0] = rx_head;
      end
      off == REG_ROUTE: begin
        rd_word[ROUTE_OUT_LSB +: CW] = out_sel;
        rd_word[ROUTE_IN_LSB +: CW]  = in_sel;
      end
      off == REG_STATUS: rd_word = status;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_dat_o <= '0;
      out_sel   <= '0;
      in_sel    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      wbs_dat_o <= rd_req ? rd_word : '0;
      if (wr_route) begin
        out_sel <= fix_sel(wbs_dat_i[ROUTE_OUT_LSB +: CW]);
        in_sel  <= fix_sel(wbs_dat_i[ROUTE_IN_LSB +: CW]);
      end
      if (wr_clear & wbs_dat_i[CLR_FLAGS]) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (wr_dat & ~tx_ready) ovf <= 1'b1;
        if (rd_dat & ~rx_valid) unf <= 1'b1;
      end
    end
  end

  always_comb begin
    m_val = '0;
    m_val[out_sel] = tx_valid;
    s_rdy = '0;
    s_rdy[in_sel] = rx_ready & wb_rst_i;
  end

  assign m_data = {N_CH{tx_head}};

endmodule

// File: tb/tb_wb_stream_hub.sv
// Directed bench for wb_stream_hub with a queue-based reference model.
// Model is compared against all outputs every cycle, plus literal checks.
module tb_wb_stream_hub;

  localparam int          DW   = 32;
  localparam int          NC   = 4;
  localparam int          DP   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_DATA  = BASE;
  localparam logic [31:0] A_ROUTE = BASE + 32'h4;
  localparam logic [31:0] A_STAT  = BASE + 32'h8;
  localparam logic [31:0] A_CLR   = BASE + 32'hC;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             stb = 1'b0;
  logic             cyc = 1'b0;
  logic             we = 1'b0;
  logic [3:0]       sel = 4'hF;
  logic [31:0]      dat_i = '0;
  logic [31:0]      adr = '0;
  logic             ack;
  logic [31:0]      dat_o;
  logic [NC-1:0]    m_val;
  logic [NC*DW-1:0] m_data;
  logic [NC-1:0]    m_rdy = '0;
  logic [NC-1:0]    s_val = '0;
  logic [NC*DW-1:0] s_data = '0;
  logic [NC-1:0]    s_rdy;

  always #5 clk = ~clk;

  wb_stream_hub #(
    .DATA_W(DW), .N_CH(NC), .DEPTH(DP), .BASE_ADDR(BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .m_val     (m_val),
    .m_data    (m_data),
    .m_rdy     (m_rdy),
    .s_val     (s_val),
    .s_data    (s_data),
    .s_rdy     (s_rdy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  int            out_m = 0;
  int            in_m = 0;
  bit            ovf_m = 0;
  bit            unf_m = 0;
  bit            busy_m = 0;
  logic [31:0]   dat_m = '0;
  int            egress_n = 0;

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    out_m = 0;
    in_m = 0;
    ovf_m = 0;
    unf_m = 0;
    busy_m = 0;
    dat_m = '0;
  endtask

  always @(posedge clk) begin
    bit          acc, tx_full, rx_empty, eg, ing;
    logic [31:0] rv;
    logic [DW-1:0] in_w;
    int          sv;
    if (rst_n) begin
      acc = !busy_m && stb && cyc && (adr[31:4] == BASE[31:4]);
      tx_full  = (tx_q.size() == DP);
      rx_empty = (rx_q.size() == 0);
      eg  = (tx_q.size() > 0) && m_rdy[out_m];
      ing = (rx_q.size() < DP) && s_val[in_m];
      in_w = s_data[in_m*DW +: DW];
      rv = 0;
      if (acc && !we) begin
        case (adr[3:2])
          2'd0: rv = rx_empty ? 32'd0 : rx_q[0];
          2'd1: rv = 32'(out_m) | (32'(in_m) << 16);
          2'd2: rv = 32'(tx_q.size()) | (32'(rx_q.size()) << 8)
                   | (32'(ovf_m) << 16) | (32'(unf_m) << 17)
                   | (32'(tx_full) << 18) | (32'(rx_empty) << 19);
          default: rv = 0;
        endcase
      end
      if (eg) begin
        void'(tx_q.pop_front());
        egress_n++;
      end
      if (acc && !we && adr[3:2] == 2'd0) begin
        if (rx_empty) unf_m = 1;
        else void'(rx_q.pop_front());
      end
      if (ing) rx_q.push_back(in_w);
      if (acc && we) begin
        case (adr[3:2])
          2'd0: begin
            if (tx_full) ovf_m = 1;
            else tx_q.push_back(dat_i[DW-1:0]);
          end
          2'd1: begin
            sv = int'(dat_i[1:0]);
            out_m = (sv >= NC) ? 0 : sv;
            sv = int'(dat_i[17:16]);
            in_m = (sv >= NC) ? 0 : sv;
          end
          2'd3: begin
            if (dat_i[0]) begin
              ovf_m = 0;
              unf_m = 0;
            end
            if (dat_i[1]) begin
              tx_q.delete();
              rx_q.delete();
            end
          end
          default: ;
        endcase
      end
      busy_m = acc;
      dat_m = rv;
    end
  end

  always @(negedge clk) begin
    logic [NC-1:0] em, es;
    em = '0;
    es = '0;
    if (rst_n && tx_q.size() > 0) em[out_m] = 1'b1;
    if (rst_n && rx_q.size() < DP) es[in_m] = 1'b1;
    chk("m_val", 128'(m_val), 128'(em));
    chk("s_rdy", 128'(s_rdy), 128'(es));
    chk("ack", 128'(ack), 128'(busy_m && rst_n));
    chk("dat_o", 128'(dat_o), 128'(busy_m ? dat_m : 32'd0));
    if (rst_n && tx_q.size() > 0)
      chk("m_data", 128'(m_data), 128'({NC{tx_q[0]}}));
  end

  task automatic wb_acc(input logic [31:0] a, input bit w,
                        input logic [31:0] d,
                        output logic [31:0] q,
                        input bit expect_ack);
    bit got;
    got = 0;
    q = '0;
    @(negedge clk);
    stb = 1;
    cyc = 1;
    we = w;
    adr = a;
    dat_i = d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1;
        q = dat_o;
        break;
      end
    end
    stb = 0;
    cyc = 0;
    we = 0;
    chk(expect_ack ? "ack_seen" : "no_ack",
        128'(got), 128'(expect_ack));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_acc(a, 1'b1, d, q, 1'b1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wb_acc(a, 1'b0, 32'd0, q, 1'b1);
  endtask

  initial begin
    logic [31:0] q;
    int e0;
    #1 rst_n = 0;
    model_reset();
    @(negedge clk);
    chk("rst_m_val", 128'(m_val), 128'(0));
    chk("rst_s_rdy", 128'(s_rdy), 128'(0));
    chk("rst_ack", 128'(ack), 128'(0));
    @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("post_rst_s_rdy", 128'(s_rdy), 128'(4'b0001));
    rd(A_STAT, q);
    chk("status_reset", 128'(q), 128'(32'h0008_0000));

    // egress on channel 2
    wr(A_ROUTE, 32'd2);
    rd(A_ROUTE, q);
    chk("route_rb", 128'(q), 128'(32'd2));
    wr(A_DATA, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("eg_m_val", 128'(m_val), 128'(4'b0100));
    chk("eg_lane2", 128'(m_data[2*DW +: DW]), 128'(32'hDEAD_BEEF));
    m_rdy = 4'b0100;
    @(negedge clk);
    m_rdy = 4'b0000;
    chk("eg_done", 128'(m_val), 128'(0));
    rd(A_STAT, q);
    chk("status_tx0", 128'(q), 128'(32'h0008_0000));

    // overflow: 9 writes into 8 entries
    for (int i = 0; i < 9; i++) wr(A_DATA, 32'h100 + i);
    chk("model_head", 128'(tx_q[0]), 128'(32'h100));
    rd(A_STAT, q);
    chk("status_ovf", 128'(q), 128'(32'h000D_0008));
    e0 = egress_n;
    m_rdy = 4'b1111;
    repeat (12) @(negedge clk);
    m_rdy = 4'b0000;
    chk("drained8", 128'(egress_n - e0), 128'(8));
    rd(A_STAT, q);
    chk("status_drain", 128'(q), 128'(32'h0009_0000));
    wr(A_CLR, 32'd1);

    // write to full TX on the same edge as an egress pop
    for (int i = 0; i < 8; i++) wr(A_DATA, 32'h200 + i);
    @(negedge clk);
    m_rdy = 4'b0100;
    stb = 1;
    cyc = 1;
    we = 1;
    adr = A_DATA;
    dat_i = 32'h999;
    @(negedge clk);
    chk("full_pop_ack", 128'(ack), 128'(1));
    stb = 0;
    cyc = 0;
    we = 0;
    m_rdy = 4'b0000;
    rd(A_STAT, q);
    chk("status_full_pop", 128'(q), 128'(32'h0009_0007));
    m_rdy = 4'b0100;
    repeat (10) @(negedge clk);
    m_rdy = 4'b0000;
    wr(A_CLR, 32'd1);

    // ingress on channel 1
    wr(A_ROUTE, 32'h0001_0000);
    @(negedge clk);
    chk("ing_s_rdy", 128'(s_rdy), 128'(4'b0010));
    s_data = {32'd0, 32'd0, 32'd7, 32'd5};
    s_val = 4'b0011;
    @(negedge clk);
    s_val = 4'b0000;
    rd(A_STAT, q);
    chk("status_rx1", 128'(q), 128'(32'h0000_0100));
    rd(A_DATA, q);
    chk("ing_data", 128'(q), 128'(32'd7));

    // underflow, then clear flags
    rd(A_DATA, q);
    chk("unf_data", 128'(q), 128'(32'd0));
    rd(A_STAT, q);
    chk("status_unf", 128'(q), 128'(32'h000A_0000));
    wr(A_CLR, 32'd1);
    rd(A_STAT, q);
    chk("status_clr", 128'(q), 128'(32'h0008_0000));

    // STATUS write ignored; unmapped access not acked
    wr(A_STAT, 32'hFFFF_FFFF);
    wb_acc(BASE + 32'h10, 1'b1, 32'h55, q, 1'b0);
    rd(A_STAT, q);
    chk("status_unmapped", 128'(q), 128'(32'h0008_0000));

    // flush
    wr(A_ROUTE, 32'd0);
    for (int i = 0; i < 3; i++) wr(A_DATA, 32'h300 + i);
    rd(A_STAT, q);
    chk("status_3", 128'(q), 128'(32'h0008_0003));
    wr(A_CLR, 32'd2);
    rd(A_STAT, q);
    chk("status_flush", 128'(q), 128'(32'h0008_0000));

    // reset mid-operation
    wr(A_ROUTE, 32'd3);
    for (int i = 0; i < 3; i++) wr(A_DATA, 32'h400 + i);
    @(negedge clk);
    chk("pre_rst_m_val", 128'(m_val), 128'(4'b1000));
    @(posedge clk);
    #2 rst_n = 0;
    model_reset();
    #1 chk("mid_rst_m_val", 128'(m_val), 128'(0));
    #4 rst_n = 1;
    rd(A_STAT, q);
    chk("status_after_rst", 128'(q), 128'(32'h0008_0000));
    rd(A_ROUTE, q);
    chk("route_after_rst", 128'(q), 128'(32'd0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
